// File: rtl/fb_pkg.sv
// Shared definitions for the 40x30 1-bit cell framebuffer (writer, reader, bench).
package fb_pkg;

  localparam int GRID_COLS   = 40;
  localparam int GRID_ROWS   = 30;
  localparam int TOTAL_CELLS = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W      = 11;
  localparam int COL_W       = 6;
  localparam int ROW_W       = 5;
  // One extra bit so the fill counter can hold TOTAL_CELLS itself, even if
  // ADDR_W were trimmed to exactly fit the grid.
  localparam int CNT_W       = ADDR_W + 1;

  typedef enum logic [1:0] {
    OP_SET  = 2'd0,
    OP_CLR  = 2'd1,
    OP_FILL = 2'd2,
    OP_RSVD = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_WIN,
    ST_WRITE,
    ST_FILL
  } state_t;

endpackage

// File: rtl/fb_cell_addr.sv
// Combinational (col,row) -> linear SRAM address plus range flag.
// Shared with the pixel-driver read side so both ends agree on the layout.
module fb_cell_addr
  import fb_pkg::*;
(
  input  logic [COL_W-1:0]  col,
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] col_ext;

  assign row_ext = ADDR_W'(row);
  assign col_ext = ADDR_W'(col);

  // row*40 as row*32 + row*8; this mapping is tied to the 40-column grid.
  assign addr = (row_ext << 5) + (row_ext << 3) + col_ext;

  assign in_range = (col < COL_W'(GRID_COLS)) && (row < ROW_W'(GRID_ROWS));

endmodule

// File: rtl/framebuffer_cell_writer.sv
// Write side of the cell framebuffer SRAM. Takes SET/CLR/FILL commands over
// valid/ready and performs the writes only while write_window is high.
//
//  state       | meaning
//  ST_IDLE     | ready for a command, pixel driver may read
//  ST_WAIT_WIN | single-cell write pending, waiting for the write window
//  ST_WRITE    | single-cell write strobe cycle, port owned by the writer
//  ST_FILL     | whole-grid fill in progress, pauses while the window is low
//
// All outputs are flops; the comb block computes their next values together
// with the next state, so every output changes on the same edge as the state.
module framebuffer_cell_writer
  import fb_pkg::*;
(
  input  logic              clk_74a,
  input  logic              reset_74a,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic              cmd_fill_val,
  input  logic              write_window,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_wr_data,
  output logic              sram_wr_en,
  output logic              sram_read_ok,
  output logic              busy,
  output logic              cmd_err
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  fill_cnt, fill_cnt_n;
  logic              ready_n, wr_en_n, wr_data_n, read_ok_n, busy_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] cell_addr;
  logic              cell_in_range;

  fb_cell_addr u_cell_addr (
    .col      (cmd_col),
    .row      (cmd_row),
    .addr     (cell_addr),
    .in_range (cell_in_range)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_n    = state;
    fill_cnt_n = fill_cnt;
    ready_n    = cmd_ready;
    addr_n     = sram_addr;
    wr_data_n  = sram_wr_data;
    read_ok_n  = sram_read_ok;
    busy_n     = busy;
    wr_en_n    = 1'b0;
    err_n      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == OP_FILL) begin
            fill_cnt_n = '0;
            wr_data_n  = cmd_fill_val;
            state_n    = ST_FILL;
            ready_n    = 1'b0;
            busy_n     = 1'b1;
            read_ok_n  = 1'b0;
          end else if ((cmd_op == OP_RSVD) || !cell_in_range) begin
            err_n = 1'b1;
          end else begin
            addr_n    = cell_addr;
            wr_data_n = (cmd_op == OP_SET);
            state_n   = ST_WAIT_WIN;
            ready_n   = 1'b0;
            busy_n    = 1'b1;
          end
        end
      end

      ST_WAIT_WIN: begin
        if (write_window) begin
          state_n   = ST_WRITE;
          wr_en_n   = 1'b1;
          read_ok_n = 1'b0;
        end
      end

      ST_WRITE: begin
        state_n   = ST_IDLE;
        ready_n   = 1'b1;
        busy_n    = 1'b0;
        read_ok_n = 1'b1;
      end

      ST_FILL: begin
        // The last strobe goes out while still in FILL, so the port stays
        // owned through it; the count reaching TOTAL_CELLS ends the fill.
        if (fill_cnt == CNT_W'(TOTAL_CELLS)) begin
          state_n   = ST_IDLE;
          ready_n   = 1'b1;
          busy_n    = 1'b0;
          read_ok_n = 1'b1;
        end else if (write_window) begin
          wr_en_n    = 1'b1;
          addr_n     = fill_cnt[ADDR_W-1:0];
          fill_cnt_n = fill_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_74a) begin
    if (reset_74a) begin
      state        <= ST_IDLE;
      fill_cnt     <= '0;
      cmd_ready    <= 1'b1;
      sram_addr    <= '0;
      sram_wr_data <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_read_ok <= 1'b1;
      busy         <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      state        <= state_n;
      fill_cnt     <= fill_cnt_n;
      cmd_ready    <= ready_n;
      sram_addr    <= addr_n;
      sram_wr_data <= wr_data_n;
      sram_wr_en   <= wr_en_n;
      sram_read_ok <= read_ok_n;
      busy         <= busy_n;
      cmd_err      <= err_n;
    end
  end

endmodule

// File: tb/tb_framebuffer_cell_writer.sv
// Bench for framebuffer_cell_writer: per-cycle reference model, directed
// scenarios with literal expectations, and a random command stream whose
// final memory image is checked against the plain command semantics.
module tb_framebuffer_cell_writer;
  import fb_pkg::*;

  logic        clk_74a = 1'b0;
  logic        reset_74a = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_col = 6'd0;
  logic [4:0]  cmd_row = 5'd0;
  logic        cmd_fill_val = 1'b0;
  logic        write_window = 1'b0;
  logic [10:0] sram_addr;
  logic        sram_wr_data;
  logic        sram_wr_en;
  logic        sram_read_ok;
  logic        busy;
  logic        cmd_err;

  framebuffer_cell_writer dut (
    .clk_74a      (clk_74a),
    .reset_74a    (reset_74a),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_col      (cmd_col),
    .cmd_row      (cmd_row),
    .cmd_fill_val (cmd_fill_val),
    .write_window (write_window),
    .sram_addr    (sram_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_en   (sram_wr_en),
    .sram_read_ok (sram_read_ok),
    .busy         (busy),
    .cmd_err      (cmd_err)
  );

  always #5 clk_74a = ~clk_74a;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Window generator: 0 = fixed level, 1 = 7 cycles on / 3 off, 2 = random.
  int win_mode = 0;
  bit win_level = 1'b1;
  int win_phase = 0;
  always @(posedge clk_74a) begin
    #1;
    if (win_mode == 1) begin
      write_window = (win_phase < 7);
      win_phase = (win_phase + 1) % 10;
    end else if (win_mode == 2) begin
      write_window = ($urandom_range(0, 3) != 0);
    end else begin
      write_window = win_level;
    end
  end

  // Reference model. Jobs: none, cell waiting for window, cell strobe, fill.
  localparam int J_NONE = 0, J_CELL_WAIT = 1, J_CELL_WR = 2, J_FILL = 3;
  int   job = J_NONE;
  int   fill_next = 0;
  int   m_addr = 0;
  bit   m_data = 1'b0;
  bit   e_we = 1'b0;
  bit   e_err = 1'b0;
  bit   model_on = 1'b0;
  bit   intended [1200];
  bit   dut_mem [1200];
  int   wr_count = 0;

  always @(posedge clk_74a) begin
    if (reset_74a) begin
      job = J_NONE;
      e_we = 1'b0;
      e_err = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      e_we = 1'b0;
      e_err = 1'b0;
      case (job)
        J_NONE: begin
          if (cmd_valid) begin
            if (cmd_op == 2'd2) begin
              job = J_FILL;
              fill_next = 0;
              m_data = cmd_fill_val;
              for (int i = 0; i < 1200; i++) intended[i] = cmd_fill_val;
            end else if (cmd_op == 2'd3 || cmd_col >= 6'd40 || cmd_row >= 5'd30) begin
              e_err = 1'b1;
            end else begin
              job = J_CELL_WAIT;
              m_addr = int'(cmd_row) * 40 + int'(cmd_col);
              m_data = (cmd_op == 2'd0);
              intended[m_addr] = m_data;
            end
          end
        end
        J_CELL_WAIT: begin
          if (write_window) begin
            job = J_CELL_WR;
            e_we = 1'b1;
          end
        end
        J_CELL_WR: job = J_NONE;
        default: begin
          if (fill_next == 1200) begin
            job = J_NONE;
          end else if (write_window) begin
            e_we = 1'b1;
            m_addr = fill_next;
            fill_next++;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_74a) begin
    if (model_on) begin
      check("cyc_ready", cmd_ready, (job == J_NONE));
      check("cyc_busy", busy, (job != J_NONE));
      check("cyc_read_ok", sram_read_ok, (job == J_NONE || job == J_CELL_WAIT));
      check("cyc_wr_en", sram_wr_en, e_we);
      check("cyc_err", cmd_err, e_err);
      if (e_we) begin
        check("cyc_addr", sram_addr, m_addr);
        check("cyc_data", sram_wr_data, m_data);
      end
    end
  end

  // Memory image as actually written by the DUT.
  always @(negedge clk_74a) begin
    if (sram_wr_en === 1'b1) begin
      wr_count++;
      if (sram_addr < 11'd1200) dut_mem[sram_addr] = sram_wr_data;
    end
  end

  task automatic send(input logic [1:0] op, input logic [5:0] col, input logic [4:0] row,
                      input logic val, output int waited);
    logic rdy;
    waited = 0;
    @(posedge clk_74a);
    #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_col = col;
    cmd_row = row;
    cmd_fill_val = val;
    forever begin
      @(negedge clk_74a);
      rdy = cmd_ready;
      @(posedge clk_74a);
      if (rdy) break;
      waited++;
      if (waited > 10000) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk_74a);
      if (!busy && cmd_ready) break;
      n++;
      if (n > 5000) begin
        check("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_wr_en"}, sram_wr_en, 0);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_data"}, sram_wr_data, 0);
    check({tag, "_read_ok"}, sram_read_ok, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, cmd_err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    int w, base, bad, got, n_wr, order_err, ro_hi, nxt, last_a, found;
    logic [10:0] cap_addr;
    logic cap_data;

    // Reset
    repeat (3) @(posedge clk_74a);
    @(negedge clk_74a);
    check_reset_values("rst");
    @(posedge clk_74a);
    #1 reset_74a = 1'b0;
    repeat (2) @(posedge clk_74a);

    // SET col=39 row=29 with window already open
    base = wr_count;
    send(2'd0, 6'd39, 5'd29, 1'b0, w);
    @(negedge clk_74a);
    check("set_wait_we", sram_wr_en, 0);
    @(negedge clk_74a);
    check("set_we", sram_wr_en, 1);
    check("set_addr", sram_addr, 1199);
    check("set_data", sram_wr_data, 1);
    check("set_read_ok", sram_read_ok, 0);
    @(negedge clk_74a);
    check("set_after_we", sram_wr_en, 0);
    check("set_after_read_ok", sram_read_ok, 1);
    check("set_after_ready", cmd_ready, 1);
    check("set_writes", wr_count - base, 1);

    // CLR col=0 row=0 with window held closed for 10 cycles
    win_level = 1'b0;
    repeat (2) @(posedge clk_74a);
    base = wr_count;
    send(2'd1, 6'd0, 5'd0, 1'b0, w);
    bad = 0;
    repeat (10) begin
      @(negedge clk_74a);
      if (!busy || cmd_ready || sram_wr_en) bad++;
    end
    check("clr_wait_hold", bad, 0);
    check("clr_no_early_write", wr_count - base, 0);
    win_level = 1'b1;
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      @(negedge clk_74a);
      if (sram_wr_en) begin
        got = 1;
        cap_addr = sram_addr;
        cap_data = sram_wr_data;
      end
    end
    check("clr_write_seen", got, 1);
    check("clr_addr", cap_addr, 0);
    check("clr_data", cap_data, 0);
    wait_idle();

    // Rejected commands: col out of range, then reserved op
    base = wr_count;
    send(2'd0, 6'd40, 5'd0, 1'b0, w);
    @(negedge clk_74a);
    check("err_col_pulse", cmd_err, 1);
    check("err_col_ready", cmd_ready, 1);
    @(negedge clk_74a);
    check("err_col_pulse_end", cmd_err, 0);
    send(2'd3, 6'd1, 5'd1, 1'b0, w);
    @(negedge clk_74a);
    check("err_op3_pulse", cmd_err, 1);
    check("err_op3_ready", cmd_ready, 1);
    @(negedge clk_74a);
    check("err_op3_pulse_end", cmd_err, 0);
    check("err_no_writes", wr_count - base, 0);

    // FILL val=1 with window 7 on / 3 off
    win_mode = 1;
    send(2'd2, 6'd0, 5'd0, 1'b1, w);
    n_wr = 0; order_err = 0; ro_hi = 0; nxt = 0; last_a = -1; found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      @(negedge clk_74a);
      if (!busy && cmd_ready) begin
        found = 1;
      end else begin
        if (sram_read_ok) ro_hi++;
        if (sram_wr_en) begin
          if (int'(sram_addr) != nxt || sram_wr_data != 1'b1) order_err++;
          nxt++;
          n_wr++;
          last_a = int'(sram_addr);
        end
      end
    end
    check("fill_done", found, 1);
    check("fill_writes", n_wr, 1200);
    check("fill_order", order_err, 0);
    check("fill_last_addr", last_a, 1199);
    check("fill_read_ok_low", ro_hi, 0);

    // Reset in the middle of a fill, then an immediate SET
    win_mode = 0;
    win_level = 1'b1;
    repeat (2) @(posedge clk_74a);
    send(2'd2, 6'd0, 5'd0, 1'b0, w);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk_74a);
      if (sram_wr_en && sram_addr == 11'd500) found = 1;
    end
    check("midfill_reached_500", found, 1);
    @(posedge clk_74a);
    #1 reset_74a = 1'b1;
    @(posedge clk_74a);
    #1 reset_74a = 1'b0;
    @(negedge clk_74a);
    check_reset_values("midfill_rst");
    send(2'd0, 6'd5, 5'd5, 1'b0, w);
    check("post_rst_accept_wait", w, 0);
    @(negedge clk_74a);
    @(negedge clk_74a);
    check("post_rst_we", sram_wr_en, 1);
    check("post_rst_addr", sram_addr, 205);
    check("post_rst_data", sram_wr_data, 1);
    wait_idle();

    // Random stream against the scoreboard memory
    win_mode = 2;
    send(2'd2, 6'd0, 5'd0, 1'b0, w);
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 29);
      if (r == 0)
        send(2'd2, 6'd0, 5'd0, 1'($urandom_range(0, 1)), w);
      else if (r == 1)
        send(2'd3, 6'($urandom_range(0, 39)), 5'($urandom_range(0, 29)), 1'b0, w);
      else if (r == 2)
        send(2'($urandom_range(0, 1)), 6'($urandom_range(40, 63)), 5'($urandom_range(0, 29)), 1'b0, w);
      else if (r == 3)
        send(2'($urandom_range(0, 1)), 6'($urandom_range(0, 39)), 5'($urandom_range(30, 31)), 1'b0, w);
      else
        send(2'($urandom_range(0, 1)), 6'($urandom_range(0, 39)), 5'($urandom_range(0, 29)), 1'b0, w);
      repeat ($urandom_range(0, 2)) @(posedge clk_74a);
    end
    wait_idle();
    bad = 0;
    for (int i = 0; i < 1200; i++) if (intended[i] != dut_mem[i]) bad++;
    check("final_mem", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
